// File: rtl/piso_en_shifter.sv
// rtl/piso_en_shifter.sv - WIDTH-bit enabled parallel-in/serial-out shifter with ready/busy/done handshake
// Optional even-parity trailer bit after the data word when PARITY_EN is defined.
module piso_en_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       CLRN,
  input  logic                       EN,
  input  logic                       start,
  input  logic [WIDTH-1:0]           PD,
  output logic                       ready,
  output logic                       busy,
  output logic                       SO,
  output logic [$clog2(WIDTH+1)-1:0] bits_left,
  output logic                       done
);

  localparam int BW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PARITY_EN
    ,PAR  = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic             so_bit;
`ifdef PARITY_EN
  logic             par;
`endif

  assign so_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];

  // SO decodes registered state only, so PD never reaches the output combinationally.
`ifdef PARITY_EN
  assign SO = ((state == SHIFT) & so_bit) | ((state == PAR) & par);
`else
  assign SO = (state == SHIFT) & so_bit;
`endif

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      state     <= IDLE;
      sr        <= '0;
      bits_left <= '0;
      done      <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b0;
`ifdef PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (EN) begin
        case (state)
          IDLE: begin
            if (start) begin
              sr        <= PD;
              bits_left <= BW'(WIDTH);
              state     <= SHIFT;
              ready     <= 1'b0;
              busy      <= 1'b1;
`ifdef PARITY_EN
              par       <= ^PD;
`endif
            end
          end
          SHIFT: begin
            sr        <= MSB_FIRST ? (sr << 1) : (sr >> 1);
            bits_left <= bits_left - BW'(1);
            if (bits_left == BW'(1)) begin
`ifdef PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
`ifdef PARITY_EN
          PAR: begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
          default: begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_en_shifter.sv
// tb/tb_piso_en_shifter.sv - directed bench for piso_en_shifter, MSB-first and LSB-first instances in parallel
// Parity trailer checks are included when PARITY_EN is defined.
module tb_piso_en_shifter;

  logic       clk = 1'b0;
  logic       CLRN;
  logic       EN;
  logic       start;
  logic [7:0] PD;

  logic       m_ready, m_busy, m_so, m_done;
  logic [3:0] m_bl;
  logic       l_ready, l_busy, l_so, l_done;
  logic [3:0] l_bl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_en_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .CLRN(CLRN), .EN(EN), .start(start), .PD(PD),
    .ready(m_ready), .busy(m_busy), .SO(m_so), .bits_left(m_bl), .done(m_done)
  );

  piso_en_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .CLRN(CLRN), .EN(EN), .start(start), .PD(PD),
    .ready(l_ready), .busy(l_busy), .SO(l_so), .bits_left(l_bl), .done(l_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both instances share stimulus; idle-state outputs must match reset values.
  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_m_ready"}, {31'd0, m_ready}, 32'd1);
    chk({tag, "_m_busy"},  {31'd0, m_busy},  32'd0);
    chk({tag, "_m_so"},    {31'd0, m_so},    32'd0);
    chk({tag, "_m_bl"},    {28'd0, m_bl},    32'd0);
    chk({tag, "_m_done"},  {31'd0, m_done},  {31'd0, exp_done});
    chk({tag, "_l_ready"}, {31'd0, l_ready}, 32'd1);
    chk({tag, "_l_busy"},  {31'd0, l_busy},  32'd0);
    chk({tag, "_l_so"},    {31'd0, l_so},    32'd0);
    chk({tag, "_l_bl"},    {28'd0, l_bl},    32'd0);
    chk({tag, "_l_done"},  {31'd0, l_done},  {31'd0, exp_done});
  endtask

  // ms/ls hold the expected serial order with the first bit in position 7.
  task automatic run_bits(input string tag, input logic [7:0] ms, input logic [7:0] ls,
                          input int first, input int last);
    for (int i = first; i <= last; i++) begin
      chk($sformatf("%s_m_so%0d", tag, i), {31'd0, m_so}, {31'd0, ms[7-i]});
      chk($sformatf("%s_l_so%0d", tag, i), {31'd0, l_so}, {31'd0, ls[7-i]});
      chk($sformatf("%s_m_bl%0d", tag, i), {28'd0, m_bl}, 32'(8 - i));
      chk($sformatf("%s_l_bl%0d", tag, i), {28'd0, l_bl}, 32'(8 - i));
      chk($sformatf("%s_busy%0d", tag, i), {30'd0, m_busy, l_busy}, 32'd3);
      chk($sformatf("%s_rdy%0d", tag, i),  {30'd0, m_ready, l_ready}, 32'd0);
      chk($sformatf("%s_done%0d", tag, i), {30'd0, m_done, l_done}, 32'd0);
      tick();
    end
  endtask

  task automatic par_cycle(input string tag, input logic exp_par);
`ifdef PARITY_EN
    chk({tag, "_par_m_so"}, {31'd0, m_so}, {31'd0, exp_par});
    chk({tag, "_par_l_so"}, {31'd0, l_so}, {31'd0, exp_par});
    chk({tag, "_par_bl"},   {24'd0, m_bl, l_bl}, 32'd0);
    chk({tag, "_par_busy"}, {30'd0, m_busy, l_busy}, 32'd3);
    chk({tag, "_par_done"}, {30'd0, m_done, l_done}, 32'd0);
    tick();
`else
    if (exp_par === 1'bx) $display("unused");
`endif
  endtask

  task automatic load(input logic [7:0] d);
    start = 1'b1;
    PD    = d;
    tick();
    start = 1'b0;
    PD    = ~d;
  endtask

  initial begin
    CLRN  = 1'b0;
    EN    = 1'b1;
    start = 1'b1;
    PD    = 8'hFF;
    tick();
    tick();
    chk_idle("reset", 1'b0);
    start = 1'b0;
    CLRN  = 1'b1;
    tick();
    chk_idle("post_reset", 1'b0);

    // Single word, PD=01; start is not re-asserted at the done cycle.
    load(8'h01);
    run_bits("w01", 8'b00000001, 8'b10000000, 0, 7);
    par_cycle("w01", 1'b1);
    chk_idle("w01_done", 1'b1);
    tick();
    chk_idle("w01_after", 1'b0);

    // Back-to-back: second start issued during the done cycle.
    load(8'h01);
    run_bits("b2b_a", 8'b00000001, 8'b10000000, 0, 7);
    par_cycle("b2b_a", 1'b1);
    chk_idle("b2b_a_done", 1'b1);
    load(8'h80);
    run_bits("b2b_b", 8'b10000000, 8'b00000001, 0, 7);
    par_cycle("b2b_b", 1'b1);
    chk_idle("b2b_b_done", 1'b1);
    tick();

    // Stall at bit 2 for three cycles; start during the stall must be ignored.
    load(8'hA5);
    run_bits("stall", 8'b10100101, 8'b10100101, 0, 1);
    EN    = 1'b0;
    start = 1'b1;
    PD    = 8'h00;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall_hold_m_so%0d", s), {31'd0, m_so}, 32'd1);
      chk($sformatf("stall_hold_l_so%0d", s), {31'd0, l_so}, 32'd1);
      chk($sformatf("stall_hold_bl%0d", s),   {24'd0, m_bl, l_bl}, 32'h66);
      chk($sformatf("stall_hold_busy%0d", s), {30'd0, m_busy, l_busy}, 32'd3);
    end
    EN    = 1'b1;
    start = 1'b0;
    run_bits("stall", 8'b10100101, 8'b10100101, 2, 7);
    par_cycle("stall", 1'b0);
    chk_idle("stall_done", 1'b1);
    tick();

    // Abort during bit 4: reset acts without waiting for an edge.
    load(8'h5B);
    run_bits("abort", 8'b01011011, 8'b11011010, 0, 3);
    CLRN = 1'b0;
    #1;
    chk_idle("abort_now", 1'b0);
    tick();
    CLRN = 1'b1;
    tick();
    chk_idle("abort_after", 1'b0);
    load(8'h5B);
    run_bits("reload", 8'b01011011, 8'b11011010, 0, 7);
    par_cycle("reload", 1'b1);
    chk_idle("reload_done", 1'b1);
    tick();

`ifdef PARITY_EN
    load(8'h07);
    run_bits("p07", 8'b00000111, 8'b11100000, 0, 7);
    par_cycle("p07", 1'b1);
    chk_idle("p07_done", 1'b1);
    tick();
    load(8'h03);
    run_bits("p03", 8'b00000011, 8'b11000000, 0, 7);
    par_cycle("p03", 1'b0);
    chk_idle("p03_done", 1'b1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
